pc_redirect_unit: RTL and testbench

//  Program-counter register and redirect sequencer directly downstream of the branch comparator.

---
 rtl/pc_redirect_unit_if.sv | 36 +++
 rtl/pc_redirect_unit.sv | 167 ++++++++++++++++
 tb/tb_pc_redirect_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_if.sv
// ============================================================================
//  Module      : pc_redirect_unit_if
//  Description : Bus bundle between the branch comparator / pipeline control
//                and the PC redirect unit.
//                  Stall, BranchValid, BranchOut, JumpValid, Target -> unit
//                  PC, PCPlus4, Flush, Busy, Trap                   <- unit
//                Modport 'master' drives the requests; modport 'slave' is the
//                PC redirect unit itself.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_redirect_unit_if;
    logic        Stall;
    logic        BranchValid;
    logic [31:0] BranchOut;
    logic        JumpValid;
    logic [31:0] Target;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Flush;
    logic        Busy;
    logic        Trap;

    modport master (
        output Stall, BranchValid, BranchOut, JumpValid, Target,
        input  PC, PCPlus4, Flush, Busy, Trap
    );

    modport slave (
        input  Stall, BranchValid, BranchOut, JumpValid, Target,
        output PC, PCPlus4, Flush, Busy, Trap
    );
endinterface

`default_nettype wire

// File: rtl/pc_redirect_unit.sv
// ============================================================================
//  Module      : pc_redirect_unit
//  Description : Program-counter register and redirect sequencer. Selects the
//                next PC from PC+4 or a taken branch / jump target, raises a
//                counted Flush to squash wrong-path fetch, and defers a
//                redirect that arrives while the pipeline is stalled.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                io_bus (slave)    Stall, BranchValid, BranchOut, JumpValid,
//                                  Target in; PC, PCPlus4, Flush, Busy, Trap
//                                  out
//  Parameters  : RESET_PC      PC loaded by reset
//                FLUSH_CYCLES  non-stalled cycles Flush stays high (1..15)
//                TRAP_VEC      PC loaded on a misaligned-target trap
//  Config      : MISALIGN_TRAP_EN  when defined, a misaligned redirect target
//                vectors to TRAP_VEC and pulses Trap; otherwise the low two
//                target bits are silently cleared and Trap stays 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pc_redirect_unit_if.slave io_bus
);

    localparam logic [3:0] c_FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_flush;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_tgt;
    logic        r_trap;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_flush_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_pend_tgt_nxt;
    logic        w_trap_nxt;
    logic        w_commit;
    logic [31:0] w_commit_tgt;
    logic        w_req;
    logic [31:0] w_pc_plus4;

    // Only zero/non-zero of the comparator result matters.
    assign w_req      = (io_bus.BranchValid && (io_bus.BranchOut != 32'd0)) || io_bus.JumpValid;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_flush_nxt    = r_flush;
        w_cnt_nxt      = r_cnt;
        w_pend_tgt_nxt = r_pend_tgt;
        w_trap_nxt     = 1'b0;
        w_commit       = 1'b0;
        w_commit_tgt   = io_bus.Target;

        case (r_state)
            ST_RUN: begin
                if (!io_bus.Stall) begin
                    if (w_req) begin
                        w_commit     = 1'b1;
                        w_commit_tgt = io_bus.Target;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end else if (w_req) begin
                    // Raw target is kept so a deferred commit can still
                    // see the low bits for the misalignment decision.
                    w_pend_tgt_nxt = io_bus.Target;
                    w_state_nxt    = ST_PENDING;
                end
            end

            ST_PENDING: begin
                // Later requests during the stall are dropped: first wins.
                if (!io_bus.Stall) begin
                    w_commit     = 1'b1;
                    w_commit_tgt = r_pend_tgt;
                end
            end

            ST_FLUSH: begin
                // Requests here come from squashed instructions.
                if (!io_bus.Stall) begin
                    w_pc_nxt = w_pc_plus4;
                    if (r_cnt == 4'd0) begin
                        w_flush_nxt = 1'b0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (w_commit) begin
            w_flush_nxt = 1'b1;
            w_cnt_nxt   = c_FLUSH_INIT;
            w_state_nxt = ST_FLUSH;
`ifdef MISALIGN_TRAP_EN
            if (w_commit_tgt[1:0] != 2'b00) begin
                w_pc_nxt   = TRAP_VEC;
                w_trap_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_commit_tgt;
            end
`else
            w_pc_nxt = {w_commit_tgt[31:2], 2'b00};
`endif
        end
    end

`ifndef MISALIGN_TRAP_EN
    // Low target bits and the trap vector have no role without the trap.
    logic w_unused_trap_inputs;
    assign w_unused_trap_inputs = ^{w_commit_tgt[1:0], TRAP_VEC};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_flush    <= 1'b0;
            r_cnt      <= 4'd0;
            r_pend_tgt <= 32'd0;
            r_trap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_flush    <= w_flush_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_trap     <= w_trap_nxt;
        end
    end

    assign io_bus.PC      = r_pc;
    assign io_bus.PCPlus4 = w_pc_plus4;
    assign io_bus.Flush   = r_flush;
    assign io_bus.Busy    = (r_state == ST_FLUSH) || (r_state == ST_PENDING);
`ifdef MISALIGN_TRAP_EN
    assign io_bus.Trap    = r_trap;
`else
    assign io_bus.Trap    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ============================================================================
//  Module      : tb_pc_redirect_unit
//  Description : Self-checking bench for pc_redirect_unit. Directed scenarios
//                followed by random traffic, all compared against a
//                cycle-level behavioural model of the redirect rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_redirect_unit_if bus ();

    pc_redirect_unit #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .TRAP_VEC     (TRAP_VEC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: remaining flush cycles and an optional deferred target.
    logic [31:0] m_pc;
    int          m_left;
    bit          m_pend;
    logic [31:0] m_ptgt;
    bit          m_trap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_redirect(input logic [31:0] t);
        m_left = FLUSH_CYCLES;
`ifdef MISALIGN_TRAP_EN
        if (t % 4 != 0) begin
            m_pc   = TRAP_VEC;
            m_trap = 1'b1;
        end else begin
            m_pc = t;
        end
`else
        m_pc = t - (t % 4);
`endif
    endtask

    task automatic model_step();
        bit req;
        req = (bus.BranchValid && bus.BranchOut != 0) || bus.JumpValid;
        m_trap = 1'b0;
        if (rst) begin
            m_pc   = RESET_PC;
            m_left = 0;
            m_pend = 1'b0;
        end else if (m_left > 0) begin
            if (!bus.Stall) begin
                m_pc   = m_pc + 32'd4;
                m_left = m_left - 1;
            end
        end else if (m_pend) begin
            if (!bus.Stall) begin
                m_pend = 1'b0;
                model_redirect(m_ptgt);
            end
        end else if (req) begin
            if (bus.Stall) begin
                m_pend = 1'b1;
                m_ptgt = bus.Target;
            end else begin
                model_redirect(bus.Target);
            end
        end else if (!bus.Stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("PC",      bus.PC,      m_pc);
        check("PCPlus4", bus.PCPlus4, m_pc + 32'd4);
        check("Flush",   {31'd0, bus.Flush}, {31'd0, m_left > 0});
        check("Busy",    {31'd0, bus.Busy},  {31'd0, (m_left > 0) || m_pend});
        check("Trap",    {31'd0, bus.Trap},  {31'd0, m_trap});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic st, input logic bv, input logic [31:0] bo,
                         input logic jv, input logic [31:0] tgt);
        bus.Stall       = st;
        bus.BranchValid = bv;
        bus.BranchOut   = bo;
        bus.JumpValid   = jv;
        bus.Target      = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_pc = 32'd0; m_left = 0; m_pend = 1'b0; m_ptgt = 32'd0; m_trap = 1'b0;

        // 1: reset then free-running fetch
        tick(); tick();
        check("t1_reset_pc", bus.PC, RESET_PC);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_pc_seq", bus.PC, RESET_PC + 32'(4 * (i + 1)));
        end

        // 2: taken branch at PC=8
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        check("t2_pc_before", bus.PC, 32'h8);
        drive(1'b0, 1'b1, 32'd1, 1'b0, 32'h40);
        tick();
        check("t2_pc_target", bus.PC, 32'h40);
        check("t2_flush_on", {31'd0, bus.Flush}, 32'd1);
        idle();
        tick();
        check("t2_pc_44", bus.PC, 32'h44);
        tick();
        check("t2_pc_48", bus.PC, 32'h48);
        check("t2_flush_off", {31'd0, bus.Flush}, 32'd0);

        // 3: not-taken branch, then a jump ignored during flush
        drive(1'b0, 1'b1, 32'd0, 1'b0, 32'h400);
        tick();
        check("t3_not_taken", bus.PC, 32'h4C);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h200);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h300);
        tick();
        check("t3_flush_ignores_req", bus.PC, 32'h204);
        idle(); tick(); tick();

        // 4: redirect deferred by stall, second request dropped
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'h80);
        tick();
        check("t4_busy_pending", {31'd0, bus.Busy}, 32'd1);
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hC0);
        tick(); tick();
        check("t4_pc_frozen", bus.PC, 32'h20C);
        idle();
        tick();
        check("t4_pc_pending", bus.PC, 32'h80);
        tick(); tick();

        // 5: misaligned target
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h42);
        tick();
`ifdef MISALIGN_TRAP_EN
        check("t5_trap_pc", bus.PC, TRAP_VEC);
        check("t5_trap", {31'd0, bus.Trap}, 32'd1);
`else
        check("t5_aligned_pc", bus.PC, 32'h40);
`endif
        idle();
        tick();
        check("t5_trap_clear", {31'd0, bus.Trap}, 32'd0);
        tick();

        // 6: reset during flush, during pending, and PC wrap
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h500);
        tick();
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_flush_pc", bus.PC, RESET_PC);
        check("t6_rst_flush_busy", {31'd0, bus.Busy}, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'h600);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; idle();
        check("t6_rst_pend_busy", {31'd0, bus.Busy}, 32'd0);
        tick();
        check("t6_after_rst_pc", bus.PC, RESET_PC + 32'd4);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        tick();
        check("t6_pcplus4_wrap", bus.PCPlus4, 32'd0);
        idle();
        tick();
        check("t6_pc_wrap", bus.PC, 32'd0);
        tick(); tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            bus.Stall       = ($urandom_range(0, 2) == 0);
            bus.BranchValid = ($urandom_range(0, 2) == 0);
            bus.BranchOut   = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            bus.JumpValid   = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       bus.Target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       bus.Target = $urandom;
                default: bus.Target = $urandom & 32'h0000_0FFC;
            endcase
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
